// File: rtl/hazard_control_unit_pkg.sv
// Shared CPU pipeline definitions used by the hazard control unit: FSM states,
// register/NOP constants and the control-vector layout driven into the pipeline.
package hazard_control_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hcu_state_e;

  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
    logic pipeHold;
  } hcu_ctrl_t;

  localparam hcu_ctrl_t CTRL_RUN = '{
    pcWrite:    1'b1,
    ifidWrite:  1'b1,
    ifidFlush:  1'b0,
    idexBubble: 1'b0,
    pipeHold:   1'b0
  };

  localparam hcu_ctrl_t CTRL_FREEZE = '{
    pcWrite:    1'b0,
    ifidWrite:  1'b0,
    ifidFlush:  1'b0,
    idexBubble: 1'b0,
    pipeHold:   1'b1
  };

  // x0 is hard-wired to zero, so a load targeting it can never create a dependency.
  function automatic logic isLoadUse(
    input logic       memread,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return memread && (rd != ZERO_REG) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle of the hazard control unit: register ids and event
// flags in, pipeline enables/flushes and performance counters out.
interface hazard_control_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           rs1_IFID;
  logic [4:0]           rs2_IFID;
  logic [4:0]           rd_IDEX;
  logic                 memread_IDEX;
  logic                 branch_taken_EX;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 pc_write;
  logic                 ifid_write;
  logic                 ifid_flush;
  logic                 idex_bubble;
  logic                 pipe_hold;
  logic                 mem_timeout;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output rs1_IFID, rs2_IFID, rd_IDEX, memread_IDEX, branch_taken_EX,
    output dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
    input  mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  rs1_IFID, rs2_IFID, rd_IDEX, memread_IDEX, branch_taken_EX,
    input  dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
    output mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush and
// load-use stall, with a sticky memory timeout and saturating statistics.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 arst_n,
  hazard_control_unit_if.slave bus
);

  localparam int WAIT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W:0]   TIMEOUT_EXT = (WAIT_W + 1)'(TIMEOUT);
  localparam logic [WAIT_W:0]   ONE_EXT     = (WAIT_W + 1)'(1);

  hcu_state_e        r_state;
  hcu_state_e        w_nextState;
  hcu_ctrl_t         w_ctrl;
  logic              w_loadUse;
  logic              w_evalPipe;
  logic              w_waitClr;
  logic              w_waitInc;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W:0]   w_waitNext;
  logic              r_memTimeout;

  assign w_loadUse  = isLoadUse(bus.memread_IDEX, bus.rd_IDEX, bus.rs1_IFID, bus.rs2_IFID);
  assign w_waitNext = {1'b0, r_waitCnt} + ONE_EXT;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Memory freeze wins outright; branch and load-use are only considered once
  // the memory stage is able to advance, and a branch squashes the load-use stall.
  always_comb begin
    w_nextState = r_state;
    w_ctrl      = CTRL_RUN;
    w_evalPipe  = 1'b0;
    w_waitClr   = 1'b0;
    w_waitInc   = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          w_ctrl      = CTRL_FREEZE;
          w_waitClr   = 1'b1;
          w_nextState = MEM_WAIT;
        end else begin
          w_evalPipe = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          w_ctrl    = CTRL_FREEZE;
          w_waitInc = 1'b1;
        end else begin
          w_evalPipe  = 1'b1;
          w_nextState = RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
    if (w_evalPipe) begin
      if (bus.branch_taken_EX) begin
        w_ctrl.ifidFlush  = 1'b1;
        w_ctrl.idexBubble = 1'b1;
      end else if (w_loadUse) begin
        w_ctrl.pcWrite    = 1'b0;
        w_ctrl.ifidWrite  = 1'b0;
        w_ctrl.idexBubble = 1'b1;
      end
    end
    if (!arst_n) begin
      w_ctrl = CTRL_RUN;
    end
  end

  // The wait counter parks at TIMEOUT so it never wraps back under the threshold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_waitCnt    <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      if (w_waitClr) begin
        r_waitCnt <= '0;
      end else if (w_waitInc && (r_waitCnt != WAIT_MAX)) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
      if (w_waitInc && (w_waitNext >= TIMEOUT_EXT)) begin
        r_memTimeout <= 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stallCounter (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_inc   (!w_ctrl.pcWrite),
    .o_count (bus.stall_cycles)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_flushCounter (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_inc   (w_ctrl.ifidFlush),
    .o_count (bus.flush_count)
  );

  assign bus.pc_write    = w_ctrl.pcWrite;
  assign bus.ifid_write  = w_ctrl.ifidWrite;
  assign bus.ifid_flush  = w_ctrl.ifidFlush;
  assign bus.idex_bubble = w_ctrl.idexBubble;
  assign bus.pipe_hold   = w_ctrl.pipeHold;
  assign bus.mem_timeout = r_memTimeout;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for the hazard control unit: two instances (wide and 2-bit counters)
// share one stimulus stream and are compared against a rule-level model.
module tb_hazard_control_unit;

  localparam int TIMEOUT_TB = 4;
  localparam int MAIN_W     = 16;
  localparam int SAT_W      = 2;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       branch;
    logic       req;
    logic       ready;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      stim;
    logic [4:0] expOut;
  } vec_t;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  bit mWaiting;
  int mWaitCycles;
  bit mTimeout;
  int mStalls;
  int mFlushes;

  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_WIDTH(MAIN_W)) busMain ();
  hazard_control_unit_if #(.CNT_WIDTH(SAT_W))  busSat ();

  assign busSat.rs1_IFID        = busMain.rs1_IFID;
  assign busSat.rs2_IFID        = busMain.rs2_IFID;
  assign busSat.rd_IDEX         = busMain.rd_IDEX;
  assign busSat.memread_IDEX    = busMain.memread_IDEX;
  assign busSat.branch_taken_EX = busMain.branch_taken_EX;
  assign busSat.dmem_req        = busMain.dmem_req;
  assign busSat.dmem_ready      = busMain.dmem_ready;

  hazard_control_unit #(.CNT_WIDTH(MAIN_W), .TIMEOUT(TIMEOUT_TB)) dutMain (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (busMain)
  );

  hazard_control_unit #(.CNT_WIDTH(SAT_W), .TIMEOUT(TIMEOUT_TB)) dutSat (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (busSat)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic stim_t mkStim(input int rs1, input int rs2, input int rd,
                                   input bit mr, input bit br, input bit rq, input bit rdy);
    stim_t s;
    s.rs1     = 5'(rs1);
    s.rs2     = 5'(rs2);
    s.rd      = 5'(rd);
    s.memread = mr;
    s.branch  = br;
    s.req     = rq;
    s.ready   = rdy;
    return s;
  endfunction

  function automatic vec_t mkVec(input string name, input stim_t s, input logic [4:0] e);
    vec_t v;
    v.name   = name;
    v.stim   = s;
    v.expOut = e;
    return v;
  endfunction

  function automatic int satVal(input int total, input int width);
    int maxVal;
    maxVal = (1 << width) - 1;
    return (total > maxVal) ? maxVal : total;
  endfunction

  // Outputs as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}.
  function automatic logic [4:0] modelOut(input stim_t s);
    bit hazard;
    bit frozen;
    hazard = s.memread && (s.rd != 5'd0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
    frozen = mWaiting ? !s.ready : (s.req && !s.ready);
    if (frozen)   return 5'b00001;
    if (s.branch) return 5'b11110;
    if (hazard)   return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic modelStep(input stim_t s, input logic [4:0] o);
    bit frozen;
    frozen = mWaiting ? !s.ready : (s.req && !s.ready);
    if (!o[4]) mStalls++;
    if (o[2])  mFlushes++;
    if (!mWaiting && frozen) begin
      mWaiting    = 1;
      mWaitCycles = 0;
    end else if (mWaiting && frozen) begin
      mWaitCycles++;
      if (mWaitCycles >= TIMEOUT_TB) mTimeout = 1;
    end else if (mWaiting) begin
      mWaiting = 0;
    end
  endtask

  task automatic modelReset();
    mWaiting    = 0;
    mWaitCycles = 0;
    mTimeout    = 0;
    mStalls     = 0;
    mFlushes    = 0;
  endtask

  task automatic driveInputs(input stim_t s);
    busMain.rs1_IFID        = s.rs1;
    busMain.rs2_IFID        = s.rs2;
    busMain.rd_IDEX         = s.rd;
    busMain.memread_IDEX    = s.memread;
    busMain.branch_taken_EX = s.branch;
    busMain.dmem_req        = s.req;
    busMain.dmem_ready      = s.ready;
  endtask

  task automatic checkCounters();
    checkOutput("stallMain", 32'(busMain.stall_cycles), 32'(satVal(mStalls, MAIN_W)));
    checkOutput("flushMain", 32'(busMain.flush_count), 32'(satVal(mFlushes, MAIN_W)));
    checkOutput("stallSat", 32'(busSat.stall_cycles), 32'(satVal(mStalls, SAT_W)));
    checkOutput("flushSat", 32'(busSat.flush_count), 32'(satVal(mFlushes, SAT_W)));
    checkOutput("timeoutMain", 32'(busMain.mem_timeout), 32'(mTimeout));
    checkOutput("timeoutSat", 32'(busSat.mem_timeout), 32'(mTimeout));
  endtask

  // Called just after a rising edge; outputs are sampled mid-cycle, state after the next edge.
  task automatic applyStimulus(input stim_t s, output logic [4:0] gotOut);
    logic [4:0] expOut;
    logic [4:0] satOut;
    driveInputs(s);
    #1;
    expOut = modelOut(s);
    gotOut = {busMain.pc_write, busMain.ifid_write, busMain.ifid_flush,
              busMain.idex_bubble, busMain.pipe_hold};
    satOut = {busSat.pc_write, busSat.ifid_write, busSat.ifid_flush,
              busSat.idex_bubble, busSat.pipe_hold};
    checkOutput("ctrlMain", 32'(gotOut), 32'(expOut));
    checkOutput("ctrlSat", 32'(satOut), 32'(expOut));
    @(posedge clk);
    #1;
    modelStep(s, expOut);
    checkCounters();
  endtask

  task automatic checkResetView(input string tag);
    checkOutput({tag, "CtrlMain"}, 32'({busMain.pc_write, busMain.ifid_write, busMain.ifid_flush,
                                        busMain.idex_bubble, busMain.pipe_hold}), 32'(5'b11000));
    checkOutput({tag, "StallMain"}, 32'(busMain.stall_cycles), 32'd0);
    checkOutput({tag, "FlushMain"}, 32'(busMain.flush_count), 32'd0);
    checkOutput({tag, "StallSat"}, 32'(busSat.stall_cycles), 32'd0);
    checkOutput({tag, "FlushSat"}, 32'(busSat.flush_count), 32'd0);
    checkOutput({tag, "TimeoutMain"}, 32'(busMain.mem_timeout), 32'd0);
  endtask

  task automatic doReset();
    driveInputs(mkStim(0, 0, 0, 0, 0, 0, 0));
    arst_n = 1'b0;
    #2;
    checkResetView("reset");
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [4:0] got;
    stim_t      s;

    vecs.push_back(mkVec("idle",          mkStim(0, 0, 0, 0, 0, 0, 0), 5'b11000));
    vecs.push_back(mkVec("loadUseRs1",    mkStim(3, 7, 3, 1, 0, 0, 0), 5'b00010));
    vecs.push_back(mkVec("loadUseRs2",    mkStim(0, 5, 5, 1, 0, 0, 0), 5'b00010));
    vecs.push_back(mkVec("zeroReg",       mkStim(0, 0, 0, 1, 0, 0, 0), 5'b11000));
    vecs.push_back(mkVec("matchNoLoad",   mkStim(6, 2, 6, 0, 0, 0, 0), 5'b11000));
    vecs.push_back(mkVec("loadNoMatch",   mkStim(1, 2, 4, 1, 0, 0, 0), 5'b11000));
    vecs.push_back(mkVec("branch",        mkStim(1, 2, 3, 0, 1, 0, 0), 5'b11110));
    vecs.push_back(mkVec("branchLoadUse", mkStim(9, 1, 9, 1, 1, 0, 0), 5'b11110));
    vecs.push_back(mkVec("memHitLoadUse", mkStim(8, 8, 8, 1, 0, 1, 1), 5'b00010));
    vecs.push_back(mkVec("memHitBranch",  mkStim(0, 0, 0, 0, 1, 1, 1), 5'b11110));
    vecs.push_back(mkVec("readyNoReq",    mkStim(2, 3, 4, 1, 0, 0, 0), 5'b11000));

    #1;
    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim, got);
      checkOutput(vecs[i].name, 32'(got), 32'(vecs[i].expOut));
    end

    // Single load-use stall
    doReset();
    applyStimulus(mkStim(0, 5, 5, 1, 0, 0, 0), got);
    checkOutput("luOut", 32'(got), 32'(5'b00010));
    checkOutput("luStall", 32'(busMain.stall_cycles), 32'd1);
    applyStimulus(mkStim(0, 5, 0, 0, 0, 0, 0), got);
    checkOutput("luAfter", 32'(got), 32'(5'b11000));

    // Branch squashes a coincident load-use stall
    doReset();
    applyStimulus(mkStim(4, 0, 4, 1, 1, 0, 0), got);
    checkOutput("brLuOut", 32'(got), 32'(5'b11110));
    checkOutput("brLuFlush", 32'(busMain.flush_count), 32'd1);
    checkOutput("brLuStall", 32'(busMain.stall_cycles), 32'd0);

    // Three-cycle memory wait
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkStim(0, 0, 0, 0, 1, 1, 0), got);
      checkOutput("memWaitHold", 32'(got), 32'(5'b00001));
    end
    applyStimulus(mkStim(0, 0, 0, 0, 0, 1, 1), got);
    checkOutput("memWaitDone", 32'(got), 32'(5'b11000));
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), got);
    checkOutput("memWaitRun", 32'(got), 32'(5'b11000));
    checkOutput("memWaitStall", 32'(busMain.stall_cycles), 32'd3);

    // Timeout after the fourth wait cycle, sticky until reset
    doReset();
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(mkStim(0, 0, 0, 0, 0, 1, 0), got);
      checkOutput("timeoutRise", 32'(busMain.mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
    end
    applyStimulus(mkStim(0, 0, 0, 0, 0, 1, 1), got);
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), got);
    checkOutput("timeoutSticky", 32'(busMain.mem_timeout), 32'd1);
    applyStimulus(mkStim(0, 0, 0, 0, 0, 1, 0), got);
    applyStimulus(mkStim(0, 0, 0, 0, 0, 1, 0), got);

    // Asynchronous reset in the middle of a wait
    s = mkStim(3, 3, 3, 1, 1, 1, 0);
    driveInputs(s);
    #1;
    checkOutput("midWaitHold", 32'(busMain.pipe_hold), 32'd1);
    #1;
    arst_n = 1'b0;
    #1;
    checkResetView("asyncReset");
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    modelReset();
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), got);
    checkOutput("runAfterReset", 32'(got), 32'(5'b11000));

    // Flush counter saturation on the narrow instance
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mkStim(0, 0, 0, 0, 1, 0, 0), got);
    end
    checkOutput("satFlush", 32'(busSat.flush_count), 32'd3);
    checkOutput("wideFlush", 32'(busMain.flush_count), 32'd5);

    // Randomized traffic against the model
    doReset();
    for (int n = 0; n < 3000; n++) begin
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.memread = 1'($urandom_range(0, 1));
      s.branch  = ($urandom_range(0, 3) == 0);
      s.req     = mWaiting ? 1'b1 : ($urandom_range(0, 3) == 0);
      s.ready   = mWaiting ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 2) != 0);
      applyStimulus(s, got);
      if ($urandom_range(0, 599) == 0) doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum number of consecutive MEM_WAIT cycles before a timeout.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 arst_n  in  1  reset, asynchronous, active-low.
REQ-005 rs1_IFID  in  5  source register 1 of the instruction in decode.
REQ-006 rs2_IFID  in  5  source register 2 of the instruction in decode.
REQ-007 rd_IDEX  in  5  destination register of the instruction in execute.
REQ-008 memread_IDEX  in  1  instruction in execute is a load.
REQ-009 branch_taken_EX  in  1  branch or jump resolved as taken in execute.
REQ-010 dmem_req  in  1  memory stage issues a data-memory access this cycle.
REQ-011 dmem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_write  out  1  PC register enable.
REQ-013 ifid_write  out  1  IF/ID register enable.
REQ-014 ifid_flush  out  1  clears IF/ID to a NOP.
REQ-015 idex_bubble  out  1  loads a NOP (all control bits 0) into ID/EX.
REQ-016 pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB.
REQ-017 mem_timeout  out  1  sticky flag: the memory wait exceeded TIMEOUT.
REQ-018 stall_cycles  out  CNT_WIDTH  saturating count of stalled cycles.
REQ-019 flush_count  out  CNT_WIDTH  saturating count of branch flushes.

Function
REQ-020 SHALL implement a two-state FSM (RUN, MEM_WAIT) with registered state and Mealy outputs decoded combinationally from state and inputs.
REQ-021 A load-use hazard SHALL be defined as: memread_IDEX=1, rd_IDEX!=0, and rd_IDEX equal to rs1_IFID or rs2_IFID.
REQ-022 Default outputs in RUN, with no event, SHALL be: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_hold=0.
REQ-023 In RUN with dmem_req=1 and dmem_ready=0, SHALL output pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0, and go to MEM_WAIT next cycle.
REQ-024 In RUN with no memory stall and branch_taken_EX=1, SHALL output ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1 (redirect).
REQ-025 In RUN with no memory stall, no branch, and a load-use hazard, SHALL output pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle.
REQ-026 Priority SHALL be: memory stall > branch flush > load-use; a branch squashes a coincident load-use stall.
REQ-027 In MEM_WAIT with dmem_ready=0, SHALL hold the freeze outputs of REQ-023 and suppress branch and load-use actions.
REQ-028 In MEM_WAIT with dmem_ready=1, SHALL evaluate REQ-024/REQ-025 as in RUN and return to RUN next cycle.
REQ-029 The wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with dmem_ready=0.
REQ-030 When the wait counter reaches TIMEOUT, mem_timeout SHALL set and remain 1 until reset; the FSM keeps waiting.
REQ-031 stall_cycles SHALL increment on every cycle with pc_write=0 and saturate at all-ones.
REQ-032 flush_count SHALL increment on every cycle with ifid_flush=1 and saturate at all-ones.
REQ-033 No combinational path SHALL exist from any output back to any input.

Reset
REQ-034 arst_n=0 SHALL asynchronously force state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0, flush_count=0.
REQ-035 During reset, outputs SHALL equal the RUN defaults (pc_write=1, ifid_write=1, others 0).
REQ-036 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release, the FSM starts in RUN.

Structure
REQ-037 The FSM state encoding and the NOP/zero-register constants SHALL live in the shared CPU package.
REQ-038 One sub-module, sat_counter (parameterised width, increment enable, async reset), SHALL be instantiated twice for stall_cycles and flush_count.

Verification
REQ-039 Load-use: memread_IDEX=1, rd_IDEX=5, rs2_IFID=5 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1.
REQ-040 Zero register: memread_IDEX=1, rd_IDEX=0, rs1_IFID=0 -> no stall; outputs stay at RUN defaults.
REQ-041 Branch with load-use: branch_taken_EX=1 with a load-use hazard in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_count=1, stall_cycles=0.
REQ-042 Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> pipe_hold=1 for 3 cycles, then RUN; stall_cycles=3.
REQ-043 Timeout: TIMEOUT=4, dmem_ready held low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after dmem_ready; cleared only by arst_n.
REQ-044 Saturation and reset: CNT_WIDTH=2, 5 flushes -> flush_count=3; assert arst_n=0 mid-wait -> all counters 0 and state RUN immediately, without waiting for a clock edge.
